// File: rtl/leg_pkg.sv
// Shared types and opcode constants for the LEG branch sequencer.
package leg_pkg;

  // Conditional opcodes handed to the external condition evaluator.
  localparam logic [7:0] OP_EQ = 8'h20;
  localparam logic [7:0] OP_NE = 8'h21;
  localparam logic [7:0] OP_LT = 8'h22;
  localparam logic [7:0] OP_LE = 8'h23;
  localparam logic [7:0] OP_GT = 8'h24;
  localparam logic [7:0] OP_GE = 8'h25;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Next-PC source select for the PC unit.
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_LOAD = 2'd1,
    PC_INC  = 2'd2,
    PC_TGT  = 2'd3
  } pc_sel_t;

  // Four fetched instruction bytes.
  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] arg1;
    logic [7:0] arg2;
    logic [7:0] target;
  } instr_t;

  // True for the opcodes resolved by the condition evaluator.
  function automatic logic is_cond(input logic [7:0] op);
    return (op >= OP_EQ) && (op <= OP_GE);
  endfunction

endpackage

// File: rtl/leg_pc_unit.sv
// Program counter register with hold / load / increment / target select.
module leg_pc_unit
  import leg_pkg::*;
#(
  parameter logic [7:0] PC_STEP  = 8'd4,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  pc_sel_t    sel_i,
  input  logic [7:0] start_pc_i,
  input  logic [7:0] target_i,
  output logic [7:0] pc_o
);

  logic [7:0] pc_q;
  logic [7:0] pc_d;

  // Next-PC mux; the increment wraps naturally at 8 bits.
  always_comb begin
    pc_d = pc_q;
    unique case (sel_i)
      PC_HOLD: pc_d = pc_q;
      PC_LOAD: pc_d = start_pc_i;
      PC_INC:  pc_d = pc_q + PC_STEP;
      PC_TGT:  pc_d = target_i;
      default: pc_d = pc_q;
    endcase
  end

  // PC register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/leg_branch_seq.sv
// LEG sequencer: fetches 4-byte instructions, resolves conditional branches
// through the external evaluator, and issues everything else to the datapath.
module leg_branch_seq
  import leg_pkg::*;
#(
  parameter logic [7:0] PC_STEP     = 8'd4,
  parameter logic [7:0] HALT_OPCODE = 8'hFF,
  parameter logic [7:0] RESET_PC    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] start_pc,
  output logic       ins_req,
  output logic [7:0] pc,
  input  logic       ins_valid,
  input  logic [7:0] ins_opcode,
  input  logic [7:0] ins_arg1,
  input  logic [7:0] ins_arg2,
  input  logic [7:0] ins_target,
  output logic [7:0] cond_opcode,
  output logic [7:0] cond_arg1,
  output logic [7:0] cond_arg2,
  input  logic       cond_result,
  output logic       exec_valid,
  output logic       branch_taken,
  output logic       halted,
  output logic       busy
);

  state_t  state_q, state_d;
  instr_t  instr_q;
  logic    instr_load;
  pc_sel_t pc_sel;

  leg_pc_unit #(
    .PC_STEP  (PC_STEP),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .sel_i      (pc_sel),
    .start_pc_i (start_pc),
    .target_i   (instr_q.target),
    .pc_o       (pc)
  );

  // State and instruction register; reset abandons any pending fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (instr_load) begin
        instr_q <= '{opcode: ins_opcode, arg1: ins_arg1,
                     arg2: ins_arg2, target: ins_target};
      end
    end
  end

  // Next state, PC select and all outputs decoded from the current state.
  always_comb begin
    state_d      = state_q;
    pc_sel       = PC_HOLD;
    instr_load   = 1'b0;
    ins_req      = 1'b0;
    cond_opcode  = 8'h00;
    cond_arg1    = 8'h00;
    cond_arg2    = 8'h00;
    exec_valid   = 1'b0;
    branch_taken = 1'b0;
    halted       = 1'b0;
    busy         = 1'b0;
    unique case (state_q)
      IDLE, HALT: begin
        halted = (state_q == HALT);
        if (start) begin
          pc_sel  = PC_LOAD;
          state_d = FETCH;
        end
      end
      FETCH: begin
        busy    = 1'b1;
        ins_req = 1'b1;
        if (ins_valid) begin
          instr_load = 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        busy        = 1'b1;
        cond_opcode = instr_q.opcode;
        cond_arg1   = instr_q.arg1;
        cond_arg2   = instr_q.arg2;
        if (is_cond(instr_q.opcode)) begin
          branch_taken = cond_result;
          pc_sel       = cond_result ? PC_TGT : PC_INC;
          state_d      = FETCH;
        end else if (instr_q.opcode == HALT_OPCODE) begin
          state_d = HALT;
        end else begin
          exec_valid = 1'b1;
          pc_sel     = PC_INC;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_leg_branch_seq.sv
// Directed bench for leg_branch_seq: one-instruction vector table plus
// hand-written stall, halt/restart, start-ignore and mid-fetch reset cases.
module tb_leg_branch_seq;

  logic       clk = 1'b0;
  logic       rst, start, ins_valid, cond_result;
  logic [7:0] start_pc, ins_opcode, ins_arg1, ins_arg2, ins_target;
  logic       ins_req, exec_valid, branch_taken, halted, busy;
  logic [7:0] pc, cond_opcode, cond_arg1, cond_arg2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  leg_branch_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_pc     (start_pc),
    .ins_req      (ins_req),
    .pc           (pc),
    .ins_valid    (ins_valid),
    .ins_opcode   (ins_opcode),
    .ins_arg1     (ins_arg1),
    .ins_arg2     (ins_arg2),
    .ins_target   (ins_target),
    .cond_opcode  (cond_opcode),
    .cond_arg1    (cond_arg1),
    .cond_arg2    (cond_arg2),
    .cond_result  (cond_result),
    .exec_valid   (exec_valid),
    .branch_taken (branch_taken),
    .halted       (halted),
    .busy         (busy)
  );

  typedef struct {
    logic [7:0] sp;
    logic [7:0] op;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] tgt;
    logic       cr;
    logic [7:0] exp_pc;
    logic       exp_br;
    logic       exp_ex;
    logic       exp_halt;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic set_instr(input logic [7:0] op, a1, a2, tgt);
    ins_opcode = op;
    ins_arg1   = a1;
    ins_arg2   = a2;
    ins_target = tgt;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; start_pc = 8'h00; ins_valid = 1'b0; cond_result = 1'b0;
    set_instr(8'h00, 8'h00, 8'h00, 8'h00);

    //           sp     op     a1     a2     tgt    cr    pc     br    ex    halt
    vecs[0] = '{8'h10, 8'h20, 8'h05, 8'h05, 8'h40, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h22, 8'h09, 8'h03, 8'h80, 1'b0, 8'h14, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'hFC, 8'h00, 8'h01, 8'h02, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h08, 8'h25, 8'h01, 8'h02, 8'h09, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h20, 8'h26, 8'h00, 8'h00, 8'h50, 1'b1, 8'h24, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h30, 8'h1F, 8'h07, 8'h08, 8'h90, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h44, 8'hFF, 8'h00, 8'h00, 8'hAA, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'h60, 8'h24, 8'h03, 8'h02, 8'h60, 1'b1, 8'h60, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'hFC, 8'h21, 8'h04, 8'h04, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

    // Reset state.
    tick();
    tick();
    chk("reset_pc", pc, 8'h00);
    chk("reset_ins_req", ins_req, 1'b0);
    chk("reset_halted", halted, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_exec_valid", exec_valid, 1'b0);
    chk("reset_branch_taken", branch_taken, 1'b0);
    chk("reset_cond_opcode", cond_opcode, 8'h00);
    rst = 1'b1;

    // Table: reset, start, one-cycle fetch, EXEC, then the following cycle.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      start = 1'b1; start_pc = vecs[i].sp;
      tick();
      start = 1'b0;
      chk("vec_fetch_pc", pc, vecs[i].sp);
      chk("vec_fetch_req", ins_req, 1'b1);
      chk("vec_fetch_cond_op", cond_opcode, 8'h00);
      ins_valid = 1'b1; cond_result = vecs[i].cr;
      set_instr(vecs[i].op, vecs[i].a1, vecs[i].a2, vecs[i].tgt);
      tick();
      ins_valid = 1'b0;
      chk("vec_exec_cond_op", cond_opcode, vecs[i].op);
      chk("vec_exec_cond_a1", cond_arg1, vecs[i].a1);
      chk("vec_exec_cond_a2", cond_arg2, vecs[i].a2);
      chk("vec_exec_branch", branch_taken, vecs[i].exp_br);
      chk("vec_exec_exec_valid", exec_valid, vecs[i].exp_ex);
      chk("vec_exec_req", ins_req, 1'b0);
      chk("vec_exec_busy", busy, 1'b1);
      tick();
      chk("vec_next_pc", pc, vecs[i].exp_pc);
      chk("vec_next_halted", halted, vecs[i].exp_halt);
      chk("vec_next_req", ins_req, !vecs[i].exp_halt);
      chk("vec_next_branch", branch_taken, 1'b0);
      chk("vec_next_exec_valid", exec_valid, 1'b0);
      $display("vec %0d: sp=%02h op=%02h cr=%0d -> pc=%02h br=%0d ex=%0d halted=%0d",
               i, vecs[i].sp, vecs[i].op, vecs[i].cr, pc,
               vecs[i].exp_br, vecs[i].exp_ex, halted);
    end

    // Fetch stall for 5 cycles, with a start attempt that must be ignored.
    do_reset();
    start = 1'b1; start_pc = 8'h10;
    tick();
    start_pc = 8'h99;
    for (int c = 0; c < 5; c++) begin
      chk("stall_req", ins_req, 1'b1);
      chk("stall_pc", pc, 8'h10);
      chk("stall_exec_valid", exec_valid, 1'b0);
      tick();
    end
    start = 1'b0;
    ins_valid = 1'b1; cond_result = 1'b0;
    set_instr(8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    ins_valid = 1'b0;
    chk("stall_exec_strobe", exec_valid, 1'b1);
    chk("stall_exec_req", ins_req, 1'b0);
    tick();
    chk("stall_next_pc", pc, 8'h14);
    $display("stall: 5 idle fetch cycles then op 00 -> pc=%02h", pc);

    // Halt, stray valid ignored, then restart from HALT at 0x20.
    ins_valid = 1'b1;
    set_instr(8'hFF, 8'h00, 8'h00, 8'h00);
    tick();
    ins_valid = 1'b0;
    tick();
    chk("halt_halted", halted, 1'b1);
    chk("halt_req", ins_req, 1'b0);
    chk("halt_pc", pc, 8'h14);
    ins_valid = 1'b1;
    tick();
    ins_valid = 1'b0;
    chk("halt_stray_pc", pc, 8'h14);
    chk("halt_stray_halted", halted, 1'b1);
    start = 1'b1; start_pc = 8'h20;
    tick();
    start = 1'b0;
    chk("restart_pc", pc, 8'h20);
    chk("restart_req", ins_req, 1'b1);
    chk("restart_halted", halted, 1'b0);
    $display("halt/restart: pc=%02h req=%0d", pc, ins_req);

    // Reset in the middle of a fetch at 0x30, then stray valid while idle.
    do_reset();
    start = 1'b1; start_pc = 8'h30;
    tick();
    start = 1'b0;
    chk("midrst_fetch_pc", pc, 8'h30);
    rst = 1'b0; ins_valid = 1'b1;
    set_instr(8'h20, 8'h01, 8'h01, 8'h70);
    tick();
    rst = 1'b1;
    chk("midrst_req", ins_req, 1'b0);
    chk("midrst_pc", pc, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    tick();
    ins_valid = 1'b0;
    chk("midrst_stray_req", ins_req, 1'b0);
    chk("midrst_stray_busy", busy, 1'b0);
    chk("midrst_stray_cond_op", cond_opcode, 8'h00);
    chk("midrst_stray_pc", pc, 8'h00);
    $display("mid-fetch reset: pc=%02h req=%0d busy=%0d", pc, ins_req, busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/leg_branch_seq.md
Name: leg_branch_seq

Overview:
- Sequencer for the LEG condition evaluator. It owns the 8-bit program counter and fetches 4-byte instructions over a request/valid handshake.
- For conditional opcodes 0x20-0x25 it drives the condition evaluator's opcode/ARG1/ARG2 inputs, samples its 1-bit result, and selects the next PC (target or PC+4).
- All other opcodes are handed to the datapath via a one-cycle exec strobe; a halt opcode parks the core.

Parameters:
- PC_STEP, 4, PC increment per instruction (bytes).
- HALT_OPCODE, 8'hFF, opcode that enters HALT.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low; all state reset on clk edge while rst==0.
- start  in  1  in IDLE/HALT: load PC from start_pc and begin fetching.
- start_pc  in  8  PC loaded on start.
- ins_req  out  1  instruction fetch request; address is pc.
- pc  out  8  current program counter.
- ins_valid  in  1  instruction bytes valid this cycle; honoured only while ins_req==1.
- ins_opcode  in  8  byte 0.
- ins_arg1  in  8  resolved operand 1.
- ins_arg2  in  8  resolved operand 2.
- ins_target  in  8  byte 3: branch target, or destination for datapath ops.
- cond_opcode  out  8  to condition evaluator opcode input.
- cond_arg1  out  8  to evaluator ARG1.
- cond_arg2  out  8  to evaluator ARG2.
- cond_result  in  1  evaluator output; combinational, sampled in EXEC.
- exec_valid  out  1  one-cycle strobe: non-branch, non-halt instruction issued to datapath.
- branch_taken  out  1  one-cycle strobe: conditional branch taken.
- halted  out  1  high in HALT.
- busy  out  1  high in FETCH or EXEC.

Behaviour:
- States: IDLE, FETCH, EXEC, HALT.
- Reset values: state=IDLE, pc=RESET_PC, instruction register=0, all strobes 0, ins_req=0, halted=0, busy=0.
- IDLE: start=1 -> pc<=start_pc, go to FETCH next cycle.
- FETCH:
  - ins_req=1.
  - ins_valid=1 -> capture all four bytes into the instruction register, go to EXEC.
  - ins_valid=0 -> stay in FETCH; no timeout.
- EXEC (exactly one cycle):
  - cond_* are driven from the instruction register.
  - Opcode 0x20..0x25: sample cond_result. If 1, pc<=ins_target and branch_taken=1; if 0, pc<=pc+PC_STEP. Go to FETCH.
  - Opcode == HALT_OPCODE: pc unchanged; go to HALT.
  - Any other opcode: exec_valid=1, pc<=pc+PC_STEP, go to FETCH.
- HALT: halted=1. start=1 -> pc<=start_pc, go to FETCH.
- cond_* outputs: valid in EXEC only. Outside EXEC they are driven to 0 (cond_opcode=0 keeps the evaluator output 0).
- Arithmetic:
  - pc+PC_STEP is modulo 256 (0xFC+4 -> 0x00).
  - Targets are used unmasked; unaligned targets are legal.
- Latency:
  - Minimum 2 cycles per instruction (1 FETCH with ins_valid already high, plus 1 EXEC).
  - Fetch for the next PC is requested in the cycle after EXEC.
- Boundary conditions:
  - ins_valid while ins_req==0 is ignored.
  - start outside IDLE/HALT is ignored.
  - Strobes are never high together; each is high at most 1 cycle per instruction.
  - Branch to self (target==pc, taken) is legal and loops.
  - rst=0 in any state, including mid-FETCH: next cycle is reset state, so ins_req drops immediately and any pending fetch is abandoned.

Decomposition:
- Package leg_pkg:
  - opcode constants OP_EQ=0x20, OP_NE=0x21, OP_LT=0x22, OP_LE=0x23, OP_GT=0x24, OP_GE=0x25;
  - function is_cond(op), true for 0x20..0x25;
  - state enum {IDLE, FETCH, EXEC, HALT}.
- One sub-module, leg_pc_unit: PC register plus next-PC mux (hold/load start_pc/increment/target).
- The condition evaluator stays external and is wired by the parent.

Test Plan:
- Reset then start, start_pc=0x10; instruction {0x20,5,5,0x40}, evaluator returns 1 -> branch_taken pulse, pc=0x40, ins_req high next cycle.
- pc=0x10; {0x22,9,3,0x80}, cond_result=0 -> no strobe, pc=0x14.
- pc=0xFC; opcode 0x00 -> exec_valid pulse, pc wraps to 0x00.
- ins_valid held low 5 cycles in FETCH -> ins_req stays high, pc stable; then valid -> EXEC one cycle later.
- Opcode 0xFF -> halted=1, pc frozen, ins_req=0; start with start_pc=0x20 -> FETCH, pc=0x20.
- rst=0 asserted during FETCH at pc=0x30 -> next cycle ins_req=0, pc=0x00, state IDLE; stray ins_valid ignored.
